// File: rtl/seq_detect_pkg.sv
// Shared constants and encodings for the run-event window counter.
package seq_detect_pkg;

  localparam int unsigned DEF_WIN_LEN = 16;
  localparam int unsigned DEF_CNT_W   = 5;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } buf_state_e;

  typedef enum logic [1:0] {
    HIT_NONE = 2'd0,
    HIT_ZERO = 2'd1,
    HIT_ONE  = 2'd2
  } hit_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] r_q;

  // Count hits, holding at the maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != CNT_MAX)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/run_event_window_counter.sv
// Counts zero-run and one-run detector hits per fixed window and reports
// each window through a one-entry valid/ready buffer with a sticky drop flag.
module run_event_window_counter
  import seq_detect_pkg::*;
#(
  parameter int unsigned WIN_LEN = DEF_WIN_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned WCNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             y,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_zero_cnt,
  output logic [CNT_W-1:0] rpt_one_cnt,
  output logic             rpt_overflow
);

  localparam logic [WCNT_W-1:0] LAST_POS = WCNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  hit_e              w_hit;
  logic              w_zhit;
  logic              w_ohit;
  logic              w_close;
  logic [CNT_W-1:0]  w_zacc;
  logic [CNT_W-1:0]  w_oacc;
  logic [CNT_W-1:0]  w_zrpt;
  logic [CNT_W-1:0]  w_orpt;

  logic [WCNT_W-1:0] r_wpos;
  buf_state_e        r_state;
  logic              r_drop_pending;
  logic [CNT_W-1:0]  r_zero_cnt;
  logic [CNT_W-1:0]  r_one_cnt;
  logic              r_overflow;

  // Classify the current sample.
  always_comb begin
    w_hit = HIT_NONE;
    if (y) begin
      w_hit = x ? HIT_ONE : HIT_ZERO;
    end
  end

  assign w_zhit  = (w_hit == HIT_ZERO);
  assign w_ohit  = (w_hit == HIT_ONE);
  assign w_close = (r_wpos == LAST_POS);

  sat_counter #(.W(CNT_W)) u_zero_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (w_close),
    .inc   (w_zhit),
    .q     (w_zacc)
  );

  sat_counter #(.W(CNT_W)) u_one_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (w_close),
    .inc   (w_ohit),
    .q     (w_oacc)
  );

  // Report values fold in the closing cycle's hit, saturated.
  always_comb begin
    w_zrpt = w_zacc;
    w_orpt = w_oacc;
    if (w_zhit && (w_zacc != CNT_MAX)) begin
      w_zrpt = w_zacc + CNT_W'(1);
    end
    if (w_ohit && (w_oacc != CNT_MAX)) begin
      w_orpt = w_oacc + CNT_W'(1);
    end
  end

  // Window position, wrapping after the last sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wpos <= '0;
    end else if (w_close) begin
      r_wpos <= '0;
    end else begin
      r_wpos <= r_wpos + WCNT_W'(1);
    end
  end

  // Output buffer: load on window close, drop and flag when still occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_EMPTY;
      r_drop_pending <= 1'b0;
      r_zero_cnt     <= '0;
      r_one_cnt      <= '0;
      r_overflow     <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_close) begin
            r_state        <= S_FULL;
            r_zero_cnt     <= w_zrpt;
            r_one_cnt      <= w_orpt;
            r_overflow     <= r_drop_pending;
            r_drop_pending <= 1'b0;
          end
        end
        S_FULL: begin
          if (w_close) begin
            if (rpt_ready) begin
              r_zero_cnt     <= w_zrpt;
              r_one_cnt      <= w_orpt;
              r_overflow     <= r_drop_pending;
              r_drop_pending <= 1'b0;
            end else begin
              r_drop_pending <= 1'b1;
            end
          end else if (rpt_ready) begin
            r_state <= S_EMPTY;
          end
        end
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  assign rpt_valid    = (r_state == S_FULL);
  assign rpt_zero_cnt = r_zero_cnt;
  assign rpt_one_cnt  = r_one_cnt;
  assign rpt_overflow = r_overflow;

endmodule

// File: tb/tb_run_event_window_counter.sv
// Directed bench for run_event_window_counter (default and CNT_W=3 instances).
module tb_run_event_window_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       x;
  logic       y;
  logic       rpt_ready;
  logic       rpt_valid;
  logic [4:0] rpt_zero_cnt;
  logic [4:0] rpt_one_cnt;
  logic       rpt_overflow;

  logic       s_valid;
  logic [2:0] s_zero_cnt;
  logic [2:0] s_one_cnt;
  logic       s_overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_event_window_counter #(.WIN_LEN(16), .CNT_W(5), .WCNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .rpt_ready    (rpt_ready),
    .rpt_valid    (rpt_valid),
    .rpt_zero_cnt (rpt_zero_cnt),
    .rpt_one_cnt  (rpt_one_cnt),
    .rpt_overflow (rpt_overflow)
  );

  run_event_window_counter #(.WIN_LEN(16), .CNT_W(3), .WCNT_W(8)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .rpt_ready    (rpt_ready),
    .rpt_valid    (s_valid),
    .rpt_zero_cnt (s_zero_cnt),
    .rpt_one_cnt  (s_one_cnt),
    .rpt_overflow (s_overflow)
  );

  task automatic step(input logic xv, input logic yv, input logic rdy);
    x         = xv;
    y         = yv;
    rpt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rpt(input string tag, input logic v, input logic [31:0] z,
                         input logic [31:0] o, input logic ov);
    chk({tag, ".valid"},    32'(rpt_valid),    32'(v));
    chk({tag, ".zero_cnt"}, 32'(rpt_zero_cnt), z);
    chk({tag, ".one_cnt"},  32'(rpt_one_cnt),  o);
    chk({tag, ".overflow"}, 32'(rpt_overflow), 32'(ov));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    x         = 1'b0;
    y         = 1'b0;
    rpt_ready = 1'b0;

    // Reset state
    do_reset();
    chk_rpt("reset", 1'b0, 0, 0, 1'b0);

    // Zero run: y on samples 2..15 -> 14 zero hits
    do_reset();
    for (int k = 0; k < 16; k++) step(1'b0, (k >= 2), 1'b1);
    chk_rpt("t1", 1'b1, 14, 0, 1'b0);
    chk("t1.sat_zero", 32'(s_zero_cnt), 7);
    step(1'b0, 1'b0, 1'b1);
    chk("t1.drain", 32'(rpt_valid), 0);

    // Mixed window: ones at 2,8,14; zeros at 5,11
    do_reset();
    for (int k = 0; k < 16; k++) step(((k % 6) < 3), ((k % 3) == 2), 1'b1);
    chk_rpt("t2", 1'b1, 2, 3, 1'b0);

    // Backpressure: window 2 dropped, window 3 flags overflow
    do_reset();
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b1, 1'b0);
      if (k == 15) chk_rpt("t3.w1", 1'b1, 0, 16, 1'b0);
      if (k == 31) chk_rpt("t3.hold_w2", 1'b1, 0, 16, 1'b0);
      if (k == 39) chk_rpt("t3.hold_end", 1'b1, 0, 16, 1'b0);
    end
    for (int k = 40; k < 48; k++) begin
      step(1'b0, 1'b0, 1'b1);
      if (k == 40) chk("t3.accept", 32'(rpt_valid), 0);
    end
    chk_rpt("t3.w3", 1'b1, 0, 8, 1'b1);
    for (int k = 48; k < 64; k++) begin
      step(1'b0, (k == 50), 1'b1);
      if (k == 48) chk("t3.accept_w3", 32'(rpt_valid), 0);
    end
    chk_rpt("t3.w4", 1'b1, 1, 0, 1'b0);

    // Accept and load in the same cycle
    do_reset();
    for (int k = 0; k < 31; k++) begin
      step((k < 4), ((k < 4) || (k >= 20 && k <= 22)), 1'b0);
      if (k == 15) chk_rpt("t4.w1", 1'b1, 0, 4, 1'b0);
    end
    chk_rpt("t4.held", 1'b1, 0, 4, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk_rpt("t4.swap", 1'b1, 3, 0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("t4.drain", 32'(rpt_valid), 0);

    // Saturation on the CNT_W=3 instance
    do_reset();
    for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 1'b1);
    chk_rpt("t5.full_width", 1'b1, 0, 16, 1'b0);
    chk("t5.sat_valid", 32'(s_valid), 1);
    chk("t5.sat_one", 32'(s_one_cnt), 7);
    chk("t5.sat_zero", 32'(s_zero_cnt), 0);

    // Reset mid-window with a held report
    do_reset();
    for (int k = 0; k < 25; k++) begin
      step((k < 2), ((k < 2) || (k >= 16 && k <= 20)), 1'b0);
      if (k == 15) chk_rpt("t6.w1", 1'b1, 0, 2, 1'b0);
    end
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk_rpt("t6.reset", 1'b0, 0, 0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, (k == 3 || k == 4), 1'b1);
      if (k == 14) chk("t6.early", 32'(rpt_valid), 0);
    end
    chk_rpt("t6.post", 1'b1, 2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
